// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin two-master Wishbone arbiter with a bus watchdog
module wb_arbiter_2m #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    input  logic                s_ack_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                owner_o,
    output logic                busy_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic [7:0] cnt;
    logic       busy;
    logic       o_cyc;
    logic       o_stb;
    logic       o_we;
    logic       timeout;

    assign busy    = state == BUSY;
    assign o_cyc   = owner ? m1_cyc_i : m0_cyc_i;
    assign o_stb   = owner ? m1_stb_i : m0_stb_i;
    assign o_we    = owner ? m1_we_i : m0_we_i;
    // A coincident ack always beats the watchdog
    assign timeout = busy && cnt == 8'(TIMEOUT_CYC - 1) && !s_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= 8'd0;
        end else if (!busy) begin
            cnt <= 8'd0;
            if (m0_cyc_i || m1_cyc_i) begin
                state <= BUSY;
                owner <= (m0_cyc_i && m1_cyc_i) ? ~last_owner : m1_cyc_i;
            end
        end else if (!o_cyc || timeout) begin
            state      <= IDLE;
            last_owner <= owner;
            cnt        <= 8'd0;
        end else begin
            cnt <= (o_stb && !s_ack_i) ? cnt + 8'd1 : 8'd0;
        end
    end

    assign s_cyc_o    = busy && o_cyc && !timeout;
    assign s_stb_o    = busy && o_stb && !timeout;
    assign s_we_o     = busy && o_we;
    assign s_addr_o   = owner ? m1_addr_i : m0_addr_i;
    assign s_wdata_o  = owner ? m1_wdata_i : m0_wdata_i;
    assign s_sel_o    = owner ? m1_sel_i : m0_sel_i;
    assign m0_ack_o   = busy && !owner && s_ack_i;
    assign m1_ack_o   = busy && owner && s_ack_i;
    assign m0_err_o   = timeout && !owner;
    assign m1_err_o   = timeout && owner;
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;
    assign owner_o    = busy ? owner : last_owner;
    assign busy_o     = busy;
endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter ADDR_W, default 32, address width on all Wishbone ports.
REQ-002 Parameter DATA_W, default 32, data width; select width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 16, bus-watchdog limit in cycles (legal range 2..255).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 mN_cyc_i, mN_stb_i, mN_we_i  input  1 each  cycle, strobe and write enable from master N (N = 0, 1).
REQ-007 mN_addr_i, mN_wdata_i, mN_sel_i  input  ADDR_W, DATA_W, DATA_W/8  address, write data and byte select from master N.
REQ-008 mN_ack_o, mN_err_o  output  1 each  transfer acknowledge and watchdog error to master N.
REQ-009 mN_rdata_o  output  DATA_W  read data to master N.
REQ-010 s_cyc_o, s_stb_o, s_we_o  output  1 each  cycle, strobe and write enable to the shared slave bus.
REQ-011 s_addr_o, s_wdata_o, s_sel_o  output  ADDR_W, DATA_W, DATA_W/8  address, write data and byte select to the shared slave bus.
REQ-012 s_ack_i  input  1  slave acknowledge; s_rdata_i  input  DATA_W  slave read data.
REQ-013 owner_o  output  1  index of the current or last bus owner; busy_o  output  1  high while a master holds the bus.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner register valid).
REQ-015 In IDLE with exactly one mN_cyc_i high, the arbiter SHALL load owner = N and enter BUSY on the next edge (grant latency 1 cycle).
REQ-016 In IDLE with both cyc inputs high, the arbiter SHALL grant the master that is not last_owner (round-robin); after reset last_owner = 1, so master 0 wins the first tie.
REQ-017 In BUSY, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o and s_sel_o SHALL be combinational copies of the owner's inputs; in IDLE, s_cyc_o and s_stb_o SHALL be 0.
REQ-018 s_ack_i SHALL be routed combinationally to the owner's mN_ack_o only; the non-owner's ack and err SHALL be 0 at all times.
REQ-019 s_rdata_i SHALL drive both mN_rdata_o outputs unmodified.
REQ-020 The owner SHALL keep the bus across multiple transfers while its cyc stays high; the other master's requests SHALL be ignored until the owner drops cyc.
REQ-021 When the owner drops cyc in BUSY, the FSM SHALL return to IDLE on the next edge and set last_owner = owner; a waiting request is granted one cycle later (one dead cycle between owners).
REQ-022 An 8-bit watchdog counter SHALL increment each BUSY cycle with owner stb high and s_ack_i low, and SHALL clear on s_ack_i, on owner stb low, or in IDLE.
REQ-023 When the counter equals TIMEOUT_CYC-1 and s_ack_i is low, the arbiter SHALL pulse the owner's mN_err_o for one cycle, force s_cyc_o and s_stb_o to 0 in that cycle, and enter IDLE on the next edge with last_owner = owner.
REQ-024 If s_ack_i and the timeout condition coincide, ack SHALL win: no err pulse, and the counter clears.
REQ-025 s_ack_i received in IDLE SHALL be ignored and SHALL NOT reach either master.
REQ-026 busy_o SHALL equal (state == BUSY); owner_o SHALL show the owner register in BUSY and last_owner in IDLE.

Reset
REQ-027 While rst_i is high at a clock edge: state = IDLE, last_owner = 1, watchdog counter = 0.
REQ-028 During and after reset, all s_* control outputs, all mN_ack_o and mN_err_o, and busy_o SHALL be 0.
REQ-029 A reset asserted mid-transfer SHALL abort the transfer with no ack or err issued; a slave ack arriving after reset is ignored per REQ-025.

Verification
REQ-030 m0 single read at addr 0x0F000000, slave acks 3 cycles after s_stb_o -> m0_ack_o asserted in the same cycle as s_ack_i, m0_rdata_o = s_rdata_i, busy_o low 1 cycle after m0 drops cyc.
REQ-031 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, m1 is granted 2 cycles later; on the next tie, m0 is granted again.
REQ-032 m1 holds cyc for 3 back-to-back writes while m0 requests -> all 3 writes reach the slave with m1 data, and m0 is granted only after m1 drops cyc.
REQ-033 TIMEOUT_CYC = 16, the slave never acks m0 -> m0_err_o pulses in the 16th stb cycle, s_cyc_o is 0 in that cycle, and the FSM returns to IDLE.
REQ-034 The slave acks in exactly the 16th cycle -> ack is delivered and no err is asserted; rst_i pulsed mid-wait -> no ack or err, and all outputs return to 0 on the next edge.
